guess_checker_seq: RTL and testbench

- Parametrised successor of the 3-digit combinational guess checker used in the number-guessing game.
- Compares an N-digit guess against an N-digit target over multiple clock cycles.
- Reports exact hits (right value, right position) and partial hits (right value, wrong position) with correct multiset handling of duplicate digits.
- Tracks attempts and win/game-over state, so the game top only has to drive start and new_game and read the results.

---
 rtl/guess_checker_seq.sv | 147 ++++++++++++++
 tb/tb_guess_checker_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/guess_checker_seq.sv
// Sequential N-digit guess checker: counts exact and partial (multiset) hits over
// DIGITS+2 cycles and tracks attempts, win and game-over for one game.
module guess_checker_seq #(
    parameter  int DIGITS    = 4,
    parameter  int DIGIT_W   = 4,
    parameter  int MAX_TRIES = 8,
    localparam int CNT_W     = $clog2(DIGITS + 1),
    localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIGITS*DIGIT_W-1:0] input_number,
    input  logic [DIGITS*DIGIT_W-1:0] target_number,
    input  logic                      start_check,
    input  logic                      new_game,
    output logic                      busy,
    output logic                      result_valid,
    output logic [CNT_W-1:0]          exact_cnt,
    output logic [CNT_W-1:0]          partial_cnt,
    output logic [TRY_W-1:0]          tries_used,
    output logic                      win,
    output logic                      game_over
);

    localparam int IDX_W = $clog2(DIGITS);

    typedef enum logic [1:0] {IDLE, EXACT, MATCH, DONE} state_t;

    state_t                            state, state_next;
    logic [DIGITS-1:0][DIGIT_W-1:0]    guess_q, target_q;
    logic [DIGITS-1:0]                 exact_mask, used_mask;
    logic [IDX_W-1:0]                  idx;
    logic [CNT_W-1:0]                  exact_acc, partial_acc;

    logic [DIGITS-1:0]                 exact_now;
    logic [CNT_W-1:0]                  exact_sum;
    logic [DIGITS-1:0]                 claim;
    logic                              claim_hit;
    logic [TRY_W-1:0]                  tries_inc;
    logic                              accept;

    assign accept    = start_check && !game_over;
    assign busy      = (state != IDLE);
    assign tries_inc = (tries_used == TRY_W'(MAX_TRIES)) ? tries_used : tries_used + 1'b1;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        exact_now = '0;
        exact_sum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            exact_now[i] = (guess_q[i] == target_q[i]);
            exact_sum    = exact_sum + CNT_W'(exact_now[i]);
        end
    end

    // Lowest unused target digit equal to the current guess digit claims the partial hit.
    always_comb begin
        claim     = '0;
        claim_hit = 1'b0;
        if (!exact_mask[idx]) begin
            for (int j = 0; j < DIGITS; j++) begin
                if (!claim_hit && !used_mask[j] && (target_q[j] == guess_q[idx])) begin
                    claim[j]  = 1'b1;
                    claim_hit = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXACT;
            EXACT:   state_next = MATCH;
            MATCH:   if (idx == IDX_W'(DIGITS - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (new_game) state_next = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand latches and masks are small registers, so they are reset with everything else.
            guess_q      <= '0;
            target_q     <= '0;
            exact_mask   <= '0;
            used_mask    <= '0;
            idx          <= '0;
            exact_acc    <= '0;
            partial_acc  <= '0;
            result_valid <= 1'b0;
            exact_cnt    <= '0;
            partial_cnt  <= '0;
            tries_used   <= '0;
            win          <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (new_game) begin
                exact_cnt   <= '0;
                partial_cnt <= '0;
                tries_used  <= '0;
                win         <= 1'b0;
                game_over   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            guess_q  <= input_number;
                            target_q <= target_number;
                        end
                    end
                    EXACT: begin
                        exact_mask  <= exact_now;
                        used_mask   <= exact_now;
                        exact_acc   <= exact_sum;
                        partial_acc <= '0;
                        idx         <= '0;
                    end
                    MATCH: begin
                        used_mask <= used_mask | claim;
                        if (claim_hit) partial_acc <= partial_acc + 1'b1;
                        if (idx != IDX_W'(DIGITS - 1)) idx <= idx + 1'b1;
                    end
                    DONE: begin
                        exact_cnt    <= exact_acc;
                        partial_cnt  <= partial_acc;
                        result_valid <= 1'b1;
                        tries_used   <= tries_inc;
                        if (exact_acc == CNT_W'(DIGITS)) win <= 1'b1;
                        if ((exact_acc == CNT_W'(DIGITS)) || (tries_inc == TRY_W'(MAX_TRIES)))
                            game_over <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_guess_checker_seq.sv
// Directed bench for guess_checker_seq (DIGITS=4, DIGIT_W=4, MAX_TRIES=8) with
// hand-computed hit counts, latency, attempt tracking and abort behaviour.
module tb_guess_checker_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] input_number;
    logic [15:0] target_number;
    logic        start_check;
    logic        new_game;
    logic        busy;
    logic        result_valid;
    logic [2:0]  exact_cnt;
    logic [2:0]  partial_cnt;
    logic [3:0]  tries_used;
    logic        win;
    logic        game_over;

    int tests = 0;
    int fails = 0;

    guess_checker_seq #(.DIGITS(4), .DIGIT_W(4), .MAX_TRIES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .input_number  (input_number),
        .target_number (target_number),
        .start_check   (start_check),
        .new_game      (new_game),
        .busy          (busy),
        .result_valid  (result_valid),
        .exact_cnt     (exact_cnt),
        .partial_cnt   (partial_cnt),
        .tries_used    (tries_used),
        .win           (win),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic start_pulse(input logic [15:0] g, input logic [15:0] t);
        @(negedge clk);
        input_number  = g;
        target_number = t;
        start_check   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_check = 1'b0;
    endtask

    task automatic wait_result(output int edges);
        edges = 0;
        while (result_valid !== 1'b1 && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (result_valid === 1'b1) pulses++;
        end
    endtask

    task automatic run_check(input string tag, input logic [15:0] g, input logic [15:0] t,
                             input int e_ex, input int e_pa, input int e_tr,
                             input int e_win, input int e_go);
        int edges;
        start_pulse(g, t);
        check({tag, " busy_after_accept"}, busy, 1);
        wait_result(edges);
        check({tag, " latency"}, edges, 6);
        check({tag, " busy_at_result"}, busy, 0);
        check({tag, " exact"}, exact_cnt, e_ex);
        check({tag, " partial"}, partial_cnt, e_pa);
        check({tag, " tries"}, tries_used, e_tr);
        check({tag, " win"}, win, e_win);
        check({tag, " game_over"}, game_over, e_go);
    endtask

    task automatic do_new_game(input string tag);
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b0;
        check({tag, " tries"}, tries_used, 0);
        check({tag, " win"}, win, 0);
        check({tag, " game_over"}, game_over, 0);
        check({tag, " exact"}, exact_cnt, 0);
        check({tag, " partial"}, partial_cnt, 0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " result_valid"}, result_valid, 0);
        check({tag, " exact"}, exact_cnt, 0);
        check({tag, " partial"}, partial_cnt, 0);
        check({tag, " tries"}, tries_used, 0);
        check({tag, " win"}, win, 0);
        check({tag, " game_over"}, game_over, 0);
    endtask

    initial begin
        int pulses;
        rst           = 1'b1;
        start_check   = 1'b0;
        new_game      = 1'b0;
        input_number  = '0;
        target_number = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("reset");

        // Full match wins immediately; later starts are ignored.
        run_check("win", 16'h1234, 16'h1234, 4, 0, 1, 1, 1);
        start_pulse(16'h1234, 16'h5678);
        check("after_win busy", busy, 0);
        count_pulses(10, pulses);
        check("after_win pulses", pulses, 0);
        check("after_win tries", tries_used, 1);

        do_new_game("ng1");
        run_check("dup", 16'h3111, 16'h1123, 1, 2, 1, 0, 0);
        run_check("ones", 16'h1111, 16'h1234, 1, 0, 2, 0, 0);
        run_check("swap", 16'h2211, 16'h1122, 0, 4, 3, 0, 0);

        // Eight misses exhaust the game; a ninth start is ignored.
        do_new_game("ng2");
        for (int i = 1; i <= 8; i++)
            run_check($sformatf("miss%0d", i), 16'h5555, 16'h1234, 0, 0, i, 0, (i == 8) ? 1 : 0);
        start_pulse(16'h1234, 16'h1234);
        check("ninth busy", busy, 0);
        count_pulses(10, pulses);
        check("ninth pulses", pulses, 0);
        check("ninth tries", tries_used, 8);

        // new_game beats a simultaneous start.
        @(negedge clk);
        input_number  = 16'h1234;
        target_number = 16'h1234;
        new_game      = 1'b1;
        start_check   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        new_game    = 1'b0;
        start_check = 1'b0;
        check("ng_start busy", busy, 0);
        check("ng_start tries", tries_used, 0);
        check("ng_start game_over", game_over, 0);
        count_pulses(8, pulses);
        check("ng_start pulses", pulses, 0);

        // Inputs and start changed mid-scan do not disturb the latched guess.
        start_pulse(16'h4321, 16'h1234);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        input_number = 16'h1234;
        start_check  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_check = 1'b0;
        count_pulses(10, pulses);
        check("midscan pulses", pulses, 1);
        check("midscan exact", exact_cnt, 0);
        check("midscan partial", partial_cnt, 4);
        check("midscan tries", tries_used, 1);

        // new_game during MATCH aborts with no result.
        start_pulse(16'h1234, 16'h1234);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b0;
        check("abort busy", busy, 0);
        check("abort tries", tries_used, 0);
        check("abort partial", partial_cnt, 0);
        count_pulses(10, pulses);
        check("abort pulses", pulses, 0);
        check("abort win", win, 0);

        // rst during EXACT clears everything; a fresh game then works.
        run_check("pre_rst", 16'h1111, 16'h1234, 1, 0, 1, 0, 0);
        start_pulse(16'h1234, 16'h1234);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("mid_rst");
        count_pulses(8, pulses);
        check("mid_rst pulses", pulses, 0);
        run_check("fresh", 16'h1234, 16'h1234, 4, 0, 1, 1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
